sw_tile_engine: RTL and testbench
=================================

Name: sw_tile_engine

Overview:
Parametrised Smith-Waterman scoring tile. It computes an N x N block of the linear-gap SW score matrix, one anti-diagonal per clock (wavefront order). It returns the bottom row and right column for chaining into the neighbouring tiles, plus the tile maximum and its position. It is the next-generation, handshake-driven scoring core for the three-level scoring system and replaces the fixed 3x3 core.

Parameters:
N, 4, tile dimension (rows = columns), N >= 2
SCW, 8, score width in bits, unsigned
MATCH, 2, score added on base match
MISMATCH, 2, score subtracted on base mismatch
GAP, 1, score subtracted per gap step (linear gap)
FLOOR, 4, minimum cell score (local-alignment floor)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
in_valid  in  1  tile inputs valid
in_ready  out  1  engine can accept a tile
seq  in  2N  query bases, 2-bit codes; row i (1..N) at bits [2(N-i)+1:2(N-i)]
targ  in  2N  target bases; column j at bits [2(N-j)+1:2(N-j)]
top_in  in  (N+1)*SCW  boundary row; element j at [j*SCW +: SCW]; element 0 = corner H(0,0)
left_in  in  N*SCW  boundary column; element i-1 = H(i,0)
out_valid  out  1  results valid
out_ready  in  1  downstream accepts results
bottom_out  out  N*SCW  H(N,j); element j-1
right_out  out  N*SCW  H(i,N); element i-1
max_out  out  SCW  tile maximum
max_row  out  $clog2(N)+1  row (1..N) of maximum
max_col  out  $clog2(N)+1  column (1..N) of maximum

Behaviour:
- Reset: rst sampled low at posedge -> state IDLE, diag counter 0, out_valid 0, bottom_out/right_out/max_out/max_row/max_col all 0, internal cell array cleared. in_ready = 1 the cycle after reset.
- Recurrence: H(i,j) = max(FLOOR, D, H(i-1,j)-GAP, H(i,j-1)-GAP).
  - D = H(i-1,j-1)+MATCH if seq base i == targ base j; otherwise H(i-1,j-1)-MISMATCH.
- Arithmetic: evaluate in SCW+2-bit signed. Clamp the result to [FLOOR, 2^SCW-1], saturating on overflow and never wrapping.
- FSM:
  - IDLE: in_ready=1. On in_valid&in_ready, register seq/targ/top_in/left_in and move to COMPUTE with d=0.
  - COMPUTE: in_ready=0. Each cycle, compute all cells with i+j-2 == d from registered neighbours. Increment d. After d == 2N-2, go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_valid&out_ready, go to IDLE and drop out_valid.
- Latency: accept edge E0. Diagonals are computed at edges E1..E(2N-1). out_valid is high after E(2N-1). With out_ready=1, the next accept is at E(2N+1), giving a throughput of one tile per 2N+1 cycles.
- in_valid asserted outside IDLE is ignored; inputs are not sampled.
- Max tracking:
  - Updated as each diagonal retires.
  - A strictly greater value replaces the current maximum.
  - Ties keep the smaller row, then the smaller column.
  - Max is reset to (FLOOR, 1, 1) at accept.
- Reset mid-operation (COMPUTE or DONE): the tile is aborted and everything returns to reset values. No partial result is ever presented.
- Outputs change only on the COMPUTE->DONE transition and on reset.

Decomposition:
- Shared package sw_pkg: base codes (A=0, C=1, G=2, T=3); default SCW, MATCH, MISMATCH, GAP, FLOOR; FSM state enum (IDLE, COMPUTE, DONE); clamp function sat_floor(value, FLOOR, SCW).
- Sub-module sw_cell: combinational processing element.
  - Inputs: diag, up, left, base_q, base_t.
  - Output: H.
  - Instantiated N*N times; the enable per cell comes from diagonal-index match.

Test Plan:
- Defaults, boundaries all 4, seq=targ=ACGT -> H(k,k)=4+2k; H(1,2)=5; max_out=12 at (4,4); bottom_out element 3=12.
- seq=AAAA, targ=CCCC, boundaries all 4 -> every cell 4; max_out=4 at (1,1) (tie rule); bottom_out/right_out all 4.
- SCW=8, boundaries all 250, seq=targ -> H(1,1)=252, H(2,2)=254, H(3,3)=H(4,4)=255 (saturated, no wrap); max_out=255 at (3,3).
- out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored; release -> one handshake, in_ready=1 next cycle.
- rst=0 while d=2 -> next cycle out_valid=0, in_ready=1, all outputs 0; a fresh tile afterwards yields the correct results.
- in_valid and out_ready held 1, two tiles back-to-back -> out_valid pulses 9 cycles apart (N=4); second result independent of the first.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman scoring tile: base codes, scoring defaults,
// FSM states and the score clamp.
package sw_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_e;

  localparam int DEF_SCW      = 8;
  localparam int DEF_MATCH    = 2;
  localparam int DEF_MISMATCH = 2;
  localparam int DEF_GAP      = 1;
  localparam int DEF_FLOOR    = 4;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  // Clamp a signed intermediate score into [floor_v, 2^scw-1]; saturates, never wraps.
  function automatic int sat_floor(input int value, input int floor_v, input int scw);
    int top_v;
    top_v = (1 << scw) - 1;
    if (value < floor_v) return floor_v;
    if (value > top_v) return top_v;
    return value;
  endfunction

endpackage

// File: rtl/sw_cell.sv
// One combinational SW processing element: H = clamp(max(D, up-GAP, left-GAP)).
// Zero latency, no handshake; the tile decides when the result is captured.
module sw_cell
  import sw_pkg::*;
#(
  parameter int SCW      = DEF_SCW,
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int GAP      = DEF_GAP,
  parameter int FLOOR    = DEF_FLOOR
) (
  input  logic [SCW-1:0] diag,
  input  logic [SCW-1:0] up,
  input  logic [SCW-1:0] left,
  input  logic [1:0]     base_q,
  input  logic [1:0]     base_t,
  output logic [SCW-1:0] h
);

  localparam logic signed [SCW+1:0] MATCH_W    = (SCW+2)'(MATCH);
  localparam logic signed [SCW+1:0] MISMATCH_W = (SCW+2)'(MISMATCH);
  localparam logic signed [SCW+1:0] GAP_W      = (SCW+2)'(GAP);

  // Two extra bits cover both the +MATCH overflow and the negative side of the subtractions.
  logic signed [SCW+1:0] d_s;
  logic signed [SCW+1:0] u_s;
  logic signed [SCW+1:0] l_s;
  logic signed [SCW+1:0] best;

  assign d_s = (base_q == base_t) ? $signed({2'b00, diag}) + MATCH_W
                                  : $signed({2'b00, diag}) - MISMATCH_W;
  assign u_s = $signed({2'b00, up}) - GAP_W;
  assign l_s = $signed({2'b00, left}) - GAP_W;

  always_comb begin
    best = d_s;
    if (u_s > best) best = u_s;
    if (l_s > best) best = l_s;
  end

  assign h = SCW'(sat_floor(int'(best), FLOOR, SCW));

endmodule

// File: rtl/sw_tile_engine.sv
// N x N Smith-Waterman tile, one anti-diagonal per clock; result valid 2N-1 clocks after accept.
// Accepts only in IDLE; results are held in DONE until out_ready, giving one tile per 2N+1 clocks.
module sw_tile_engine
  import sw_pkg::*;
#(
  parameter int N        = 4,
  parameter int SCW      = DEF_SCW,
  parameter int MATCH    = DEF_MATCH,
  parameter int MISMATCH = DEF_MISMATCH,
  parameter int GAP      = DEF_GAP,
  parameter int FLOOR    = DEF_FLOOR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*N-1:0]         seq,
  input  logic [2*N-1:0]         targ,
  input  logic [(N+1)*SCW-1:0]   top_in,
  input  logic [N*SCW-1:0]       left_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*SCW-1:0]       bottom_out,
  output logic [N*SCW-1:0]       right_out,
  output logic [SCW-1:0]         max_out,
  output logic [$clog2(N):0]     max_row,
  output logic [$clog2(N):0]     max_col
);

  localparam int RW = $clog2(N) + 1;
  localparam int DW = $clog2(2*N);

  state_t                 state;
  logic [DW-1:0]          d_cnt;
  logic [2*N-1:0]         seq_r;
  logic [2*N-1:0]         targ_r;
  logic [(N+1)*SCW-1:0]   top_r;
  logic [N*SCW-1:0]       left_r;
  logic [SCW-1:0]         h_r    [N][N];
  logic [SCW-1:0]         cell_h [N][N];
  logic [SCW-1:0]         run_max;
  logic [RW-1:0]          run_row;
  logic [RW-1:0]          run_col;
  logic [SCW-1:0]         best_v;
  logic [RW-1:0]          best_r;
  logic [RW-1:0]          best_c;

  // Array index [r][c] holds H(r+1, c+1); row 0 / column 0 come from the boundary inputs.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [SCW-1:0] diag_v;
      logic [SCW-1:0] up_v;
      logic [SCW-1:0] left_v;

      if (r == 0) begin : g_diag_top
        assign diag_v = top_r[c*SCW +: SCW];
      end else if (c == 0) begin : g_diag_left
        assign diag_v = left_r[(r-1)*SCW +: SCW];
      end else begin : g_diag_cell
        assign diag_v = h_r[r-1][c-1];
      end

      if (r == 0) begin : g_up_top
        assign up_v = top_r[(c+1)*SCW +: SCW];
      end else begin : g_up_cell
        assign up_v = h_r[r-1][c];
      end

      if (c == 0) begin : g_left_bnd
        assign left_v = left_r[r*SCW +: SCW];
      end else begin : g_left_cell
        assign left_v = h_r[r][c-1];
      end

      sw_cell #(
        .SCW(SCW), .MATCH(MATCH), .MISMATCH(MISMATCH), .GAP(GAP), .FLOOR(FLOOR)
      ) u_cell (
        .diag   (diag_v),
        .up     (up_v),
        .left   (left_v),
        .base_q (seq_r[2*(N-1-r) +: 2]),
        .base_t (targ_r[2*(N-1-c) +: 2]),
        .h      (cell_h[r][c])
      );
    end
  end

  // Fold the retiring diagonal into the running maximum; ties go to the smaller (row, col).
  always_comb begin
    best_v = run_max;
    best_r = run_row;
    best_c = run_col;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r + c == int'(d_cnt)) begin
          if (cell_h[r][c] > best_v ||
              (cell_h[r][c] == best_v &&
               (RW'(r+1) < best_r || (RW'(r+1) == best_r && RW'(c+1) < best_c)))) begin
            best_v = cell_h[r][c];
            best_r = RW'(r+1);
            best_c = RW'(c+1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      d_cnt      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      seq_r      <= '0;
      targ_r     <= '0;
      top_r      <= '0;
      left_r     <= '0;
      run_max    <= '0;
      run_row    <= '0;
      run_col    <= '0;
      bottom_out <= '0;
      right_out  <= '0;
      max_out    <= '0;
      max_row    <= '0;
      max_col    <= '0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          h_r[r][c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            seq_r    <= seq;
            targ_r   <= targ;
            top_r    <= top_in;
            left_r   <= left_in;
            d_cnt    <= '0;
            run_max  <= SCW'(FLOOR);
            run_row  <= RW'(1);
            run_col  <= RW'(1);
            in_ready <= 1'b0;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              if (r + c == int'(d_cnt)) h_r[r][c] <= cell_h[r][c];
          run_max <= best_v;
          run_row <= best_r;
          run_col <= best_c;
          d_cnt   <= d_cnt + 1'b1;
          if (d_cnt == DW'(2*N-2)) begin
            // H(N,N) is only available combinationally on this last edge.
            for (int k = 0; k < N; k++) begin
              bottom_out[k*SCW +: SCW] <= (k == N-1) ? cell_h[N-1][N-1] : h_r[N-1][k];
              right_out[k*SCW +: SCW]  <= (k == N-1) ? cell_h[N-1][N-1] : h_r[k][N-1];
            end
            max_out   <= best_v;
            max_row   <= best_r;
            max_col   <= best_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_tile_engine.sv
// Directed, table-driven bench for the 4x4 SW tile with hand-computed score matrices.
module tb_sw_tile_engine;

  localparam int N   = 4;
  localparam int SCW = 8;

  typedef struct {
    logic [7:0]  seq;
    logic [7:0]  targ;
    logic [39:0] top;
    logic [31:0] left;
    logic [31:0] bottom;
    logic [31:0] right;
    logic [7:0]  mx;
    logic [2:0]  row;
    logic [2:0]  col;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  seq;
  logic [7:0]  targ;
  logic [39:0] top_in;
  logic [31:0] left_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] bottom_out;
  logic [31:0] right_out;
  logic [7:0]  max_out;
  logic [2:0]  max_row;
  logic [2:0]  max_col;

  int errors = 0;
  int checks = 0;
  vec_t vecs [5];

  sw_tile_engine #(
    .N(N), .SCW(SCW), .MATCH(2), .MISMATCH(2), .GAP(1), .FLOOR(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .seq        (seq),
    .targ       (targ),
    .top_in     (top_in),
    .left_in    (left_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bottom_out (bottom_out),
    .right_out  (right_out),
    .max_out    (max_out),
    .max_row    (max_row),
    .max_col    (max_col)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int k);
    seq     = vecs[k].seq;
    targ    = vecs[k].targ;
    top_in  = vecs[k].top;
    left_in = vecs[k].left;
  endtask

  task automatic check_outputs(input int k);
    check($sformatf("bottom_out[v%0d]", k), bottom_out, vecs[k].bottom);
    check($sformatf("right_out[v%0d]", k),  right_out,  vecs[k].right);
    check($sformatf("max_out[v%0d]", k),    max_out,    vecs[k].mx);
    check($sformatf("max_row[v%0d]", k),    max_row,    vecs[k].row);
    check($sformatf("max_col[v%0d]", k),    max_col,    vecs[k].col);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_bottom"},    bottom_out, 0);
    check({tag, "_right"},     right_out,  0);
    check({tag, "_max"},       max_out,    0);
    check({tag, "_row"},       max_row,    0);
    check({tag, "_col"},       max_col,    0);
  endtask

  // Accept one tile, time its latency, check the result and complete the handshake.
  task automatic run_vec(input int k);
    int cnt;
    @(negedge clk);
    apply(k);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("latency[v%0d]", k), cnt, 2*N-1);
    check_outputs(k);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("out_valid_drop[v%0d]", k), out_valid, 0);
    check($sformatf("in_ready_back[v%0d]", k),  in_ready,  1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, pulses, t1, t2;

    // Boundaries: top element j at byte j (0 = corner), left element i-1 at byte i-1.
    vecs[0] = '{8'h1B, 8'h1B, {5{8'd4}},   {4{8'd4}},   32'h0C090604, 32'h0C090604, 8'd12,  3'd4, 3'd4};
    vecs[1] = '{8'h00, 8'h55, {5{8'd4}},   {4{8'd4}},   32'h04040404, 32'h04040404, 8'd4,   3'd1, 3'd1};
    vecs[2] = '{8'h00, 8'h00, {5{8'd250}}, {4{8'd250}}, 32'hFFFFFEFC, 32'hFFFFFEFC, 8'd255, 3'd3, 3'd3};
    vecs[3] = '{8'h1B, 8'hE4, {5{8'd0}},   {4{8'd0}},   32'h04040504, 32'h04040504, 8'd6,   3'd2, 3'd3};
    vecs[4] = '{8'h00, 8'h55, {5{8'd10}},  {4{8'd4}},   32'h06060606, 32'h06070809, 8'd9,   3'd1, 3'd1};

    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    apply(0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_zero("reset");

    for (int k = 0; k < 5; k++) run_vec(k);

    // Backpressure: results held, new requests ignored, single handshake on release.
    @(negedge clk);
    apply(3);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("bp_latency", cnt, 2*N-1);
    for (int i = 0; i < 10; i++) begin
      apply(0);
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp_out_valid[%0d]", i), out_valid, 1);
      check($sformatf("bp_in_ready[%0d]", i),  in_ready,  0);
      check($sformatf("bp_bottom[%0d]", i),    bottom_out, vecs[3].bottom);
      check($sformatf("bp_max[%0d]", i),       max_out,    vecs[3].mx);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready",  in_ready,  1);
    check("bp_release_max_held",  max_out,   vecs[3].mx);
    @(negedge clk);
    check("bp_no_spurious_accept", in_ready, 1);

    // Reset while diagonal 2 is pending aborts the tile.
    @(negedge clk);
    apply(1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_zero("midrst");
    run_vec(2);

    // Back-to-back tiles with in_valid and out_ready held high.
    @(negedge clk);
    apply(0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    pulses = 0;
    t1 = -1;
    t2 = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 0) apply(4);
      if (out_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          t1 = cyc;
          check_outputs(0);
        end else if (pulses == 2) begin
          t2 = cyc;
          check_outputs(4);
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b_pulses", pulses, 2);
    check("b2b_first_latency", t1, 2*N-1);
    check("b2b_spacing", t2 - t1, 2*N+1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
